// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I(+M) control decoder: opcodes, funct7 values,
// select-field encodings and the packed control word carried from D into E.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [2:0] {
    RES_ALU   = 3'b000,
    RES_MEM   = 3'b001,
    RES_PC4   = 3'b010,
    RES_IMM   = 3'b011,
    RES_PCIMM = 3'b100
  } result_src_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10,
    ALU_MULDIV = 2'b11
  } alu_op_e;

  // Bit order of the control word, MSB first.
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    result_src_e result_src;
    logic        alu_src;
    alu_op_e     alu_op;
    logic        jump;
    logic        jalr;
    logic        branch;
    logic        muldiv;
  } ctrl_word_t;

  localparam int         CTRL_W    = $bits(ctrl_word_t);
  localparam ctrl_word_t CTRL_NONE = '0;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational RV32I(+M) main decoder: instruction -> control word,
// immediate select and illegal flag. M-extension legality follows MULDIV_EN.
module ctrl_decode_comb
  import ctrl_pkg::*;
(
  input  logic [31:0]       i_instr,
  output logic [2:0]        o_imm_src,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_legal;
  imm_src_e   w_imm_src;
  ctrl_word_t w_ctrl;
  logic       w_unused;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_ctrl    = CTRL_NONE;
    w_imm_src = IMM_I;
    w_legal   = 1'b0;
    case (w_opcode)
      OP_LOAD: begin
        w_legal           = (w_funct3 != 3'b011) && (w_funct3[2:1] != 2'b11);
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        w_legal          = (w_funct3 <= 3'b010);
        w_imm_src        = IMM_S;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      OP_RTYPE: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_FUNCT;
        if (w_funct7 == F7_BASE) begin
          w_legal = 1'b1;
        end else if (w_funct7 == F7_ALT) begin
          w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
        end
`ifdef MULDIV_EN
        else if (w_funct7 == F7_MULDIV) begin
          w_legal       = 1'b1;
          w_ctrl.alu_op = ALU_MULDIV;
          w_ctrl.muldiv = 1'b1;
        end
`endif
      end
      OP_BRANCH: begin
        w_legal       = (w_funct3[2:1] != 2'b01);
        w_imm_src     = IMM_B;
        w_ctrl.alu_op = ALU_BRANCH;
        w_ctrl.branch = 1'b1;
      end
      OP_IALU: begin
        // Shift-immediates reuse imm[11:5] as a funct7 field.
        case (w_funct3)
          3'b001:  w_legal = (w_funct7 == F7_BASE);
          3'b101:  w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
          default: w_legal = 1'b1;
        endcase
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALU_FUNCT;
      end
      OP_JAL: begin
        w_legal           = 1'b1;
        w_imm_src         = IMM_J;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.result_src = RES_PC4;
      end
      OP_JALR: begin
        w_legal           = (w_funct3 == 3'b000);
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.jalr       = 1'b1;
        w_ctrl.result_src = RES_PC4;
      end
      OP_LUI: begin
        w_legal           = 1'b1;
        w_imm_src         = IMM_U;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        w_legal           = 1'b1;
        w_imm_src         = IMM_U;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_PCIMM;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_ctrl = CTRL_NONE;
    end
  end

  assign o_imm_src = w_imm_src;
  assign o_ctrl    = w_ctrl;
  assign o_illegal = !w_legal;

endmodule

// File: rtl/ctrl_decode_stage.sv
// RV32I(+M) control decoder fused with the ID/EX control register, illegal
// counter and divide busy FSM. Define MULDIV_EN to enable the M extension.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int ILL_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          InstrD,
  input  logic                 ValidD,
  input  logic                 StallE,
  input  logic                 FlushE,
  output logic [2:0]           ImmSrcD,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic [2:0]           ResultSrcE,
  output logic                 ALUSrcE,
  output logic [1:0]           ALUOpE,
  output logic                 JumpE,
  output logic                 JalrE,
  output logic                 BranchE,
  output logic [2:0]           Funct3E,
  output logic                 ValidE,
  output logic                 IllegalE,
  output logic                 MulDivE,
  output logic                 BusyD,
  output logic [ILL_CNT_W-1:0] IllegalCount
);

  logic [CTRL_W-1:0]    w_ctrl_bits;
  ctrl_word_t           w_ctrl;
  logic                 w_illegal;
  logic                 w_busy;
  logic                 w_load;
  ctrl_word_t           r_ctrl;
  logic [2:0]           r_funct3;
  logic                 r_valid;
  logic                 r_illegal;
  logic [ILL_CNT_W-1:0] r_ill_cnt;

  ctrl_decode_comb u_decode (
    .i_instr  (InstrD),
    .o_imm_src(ImmSrcD),
    .o_ctrl   (w_ctrl_bits),
    .o_illegal(w_illegal)
  );

  assign w_ctrl = ctrl_word_t'(w_ctrl_bits);
  assign w_load = !FlushE && !w_busy && !StallE;

  // Flush beats the divide hold, which beats the hazard stall.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset || FlushE) begin
      r_ctrl    <= CTRL_NONE;
      r_funct3  <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_load) begin
      r_ctrl    <= ValidD ? w_ctrl : CTRL_NONE;
      r_funct3  <= (ValidD && !w_illegal) ? InstrD[14:12] : 3'b000;
      r_valid   <= ValidD;
      r_illegal <= ValidD && w_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ill_cnt <= '0;
    end else if (w_load && ValidD && w_illegal && (r_ill_cnt != '1)) begin
      r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
    end
  end

`ifdef MULDIV_EN
  localparam int             CNT_W  = $clog2(DIV_CYCLES);
  localparam logic [0:0]     S_IDLE = 1'b0;
  localparam logic [0:0]     S_DIV  = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_div_cnt;
  logic             w_start_div;

  assign w_start_div = w_load && ValidD && w_ctrl.muldiv && InstrD[14];

  // The divide leaves DIV as the counter steps from 1 to 0, so BusyD spans DIV_CYCLES-1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_start_div) begin
        r_state   <= S_DIV;
        r_div_cnt <= CNT_W'(DIV_CYCLES - 1);
      end
    end else if (FlushE || (r_div_cnt == CNT_W'(1))) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt - CNT_W'(1);
    end
  end

  assign w_busy = (r_state == S_DIV);
`else
  localparam int unused_div_cycles = DIV_CYCLES;

  assign w_busy = 1'b0;
`endif

  assign RegWriteE    = r_ctrl.reg_write;
  assign MemWriteE    = r_ctrl.mem_write;
  assign ResultSrcE   = r_ctrl.result_src;
  assign ALUSrcE      = r_ctrl.alu_src;
  assign ALUOpE       = r_ctrl.alu_op;
  assign JumpE        = r_ctrl.jump;
  assign JalrE        = r_ctrl.jalr;
  assign BranchE      = r_ctrl.branch;
  assign MulDivE      = r_ctrl.muldiv;
  assign Funct3E      = r_funct3;
  assign ValidE       = r_valid;
  assign IllegalE     = r_illegal;
  assign BusyD        = w_busy;
  assign IllegalCount = r_ill_cnt;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: an instruction-level reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_ctrl_decode_stage;

  localparam int DIV_CYCLES = 32;
  localparam int ILL_CNT_W  = 8;
  localparam int ILL_MAX    = (1 << ILL_CNT_W) - 1;
`ifdef MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] ADD      = 32'h0031_00B3;
  localparam logic [31:0] LW       = 32'h0002_A303;
  localparam logic [31:0] AUIPC    = 32'h0000_1297;
  localparam logic [31:0] SW       = 32'h0020_A023;
  localparam logic [31:0] BEQ      = 32'h0020_8463;
  localparam logic [31:0] JAL      = 32'h0000_00EF;
  localparam logic [31:0] LUI      = 32'h0000_12B7;
  localparam logic [31:0] JALR_BAD = 32'h0001_10E7;
  localparam logic [31:0] DIV      = 32'h0231_40B3;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] InstrD = '0;
  logic        ValidD = 1'b0;
  logic        StallE = 1'b0;
  logic        FlushE = 1'b0;
  logic [2:0]  ImmSrcD, ResultSrcE, Funct3E;
  logic [1:0]  ALUOpE;
  logic        RegWriteE, MemWriteE, ALUSrcE, JumpE, JalrE, BranchE;
  logic        ValidE, IllegalE, MulDivE, BusyD;
  logic [ILL_CNT_W-1:0] IllegalCount;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.DIV_CYCLES(DIV_CYCLES), .ILL_CNT_W(ILL_CNT_W)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ValidD(ValidD),
    .StallE(StallE), .FlushE(FlushE), .ImmSrcD(ImmSrcD),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .ALUOpE(ALUOpE), .JumpE(JumpE), .JalrE(JalrE),
    .BranchE(BranchE), .Funct3E(Funct3E), .ValidE(ValidE), .IllegalE(IllegalE),
    .MulDivE(MulDivE), .BusyD(BusyD), .IllegalCount(IllegalCount)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected E-stage contents of one instruction, derived from the ISA rules.
  typedef struct packed {
    logic       rw;
    logic       mw;
    logic [2:0] rs;
    logic       as;
    logic [1:0] op;
    logic       j;
    logic       jr;
    logic       br;
    logic       md;
    logic       ill;
    logic       div;
    logic [2:0] f3;
    logic [2:0] imm;
  } dec_t;

  function automatic dec_t model_decode(input logic [31:0] ins);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         legal;
    d  = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    legal = 1'b1;
    case (ins[6:0])
      7'h03: begin legal = !(f3 == 3 || f3 == 6 || f3 == 7); d.rw = 1; d.as = 1; d.rs = 1; end
      7'h23: begin legal = (f3 <= 2); d.imm = 1; d.mw = 1; d.as = 1; end
      7'h33: begin
        legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && MD_EN);
        d.rw = 1;
        d.op = (f7 == 1) ? 2'd3 : 2'd2;
        d.md = (f7 == 1);
      end
      7'h63: begin legal = (f3 != 2 && f3 != 3); d.imm = 2; d.op = 1; d.br = 1; end
      7'h13: begin
        if (f3 == 1)      legal = (f7 == 0);
        else if (f3 == 5) legal = (f7 == 0 || f7 == 7'h20);
        d.rw = 1; d.as = 1; d.op = 2;
      end
      7'h6F: begin d.imm = 3; d.rw = 1; d.j = 1; d.rs = 2; end
      7'h67: begin legal = (f3 == 0); d.rw = 1; d.as = 1; d.jr = 1; d.rs = 2; end
      7'h37: begin d.imm = 4; d.rw = 1; d.rs = 3; end
      7'h17: begin d.imm = 4; d.rw = 1; d.rs = 4; end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      d.f3  = f3;
      d.div = d.md && f3[2];
    end else begin
      d     = '{imm: d.imm, default: '0};
      d.ill = 1'b1;
    end
    return d;
  endfunction

  dec_t m_dec;
  dec_t m_e;
  logic m_valid;
  int   m_ill_cnt;
  int   m_busy_left;
  bit   cmp_en = 1'b0;

  always_comb m_dec = model_decode(InstrD);

  always @(posedge clk) begin
    if (reset) begin
      m_e <= '0; m_valid <= 1'b0; m_ill_cnt <= 0; m_busy_left <= 0;
    end else if (FlushE) begin
      m_e <= '0; m_valid <= 1'b0; m_busy_left <= 0;
    end else if (m_busy_left > 0) begin
      m_busy_left <= m_busy_left - 1;
    end else if (!StallE) begin
      m_valid <= ValidD;
      m_e     <= ValidD ? m_dec : '0;
      if (ValidD && m_dec.ill && m_ill_cnt < ILL_MAX) m_ill_cnt <= m_ill_cnt + 1;
      if (ValidD && m_dec.div) m_busy_left <= DIV_CYCLES - 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ImmSrcD",      ImmSrcD,      m_dec.imm);
      check("RegWriteE",    RegWriteE,    m_e.rw);
      check("MemWriteE",    MemWriteE,    m_e.mw);
      check("ResultSrcE",   ResultSrcE,   m_e.rs);
      check("ALUSrcE",      ALUSrcE,      m_e.as);
      check("ALUOpE",       ALUOpE,       m_e.op);
      check("JumpE",        JumpE,        m_e.j);
      check("JalrE",        JalrE,        m_e.jr);
      check("BranchE",      BranchE,      m_e.br);
      check("MulDivE",      MulDivE,      m_e.md);
      check("Funct3E",      Funct3E,      m_e.f3);
      check("ValidE",       ValidE,       m_valid);
      check("IllegalE",     IllegalE,     m_e.ill);
      check("BusyD",        BusyD,        m_busy_left > 0);
      check("IllegalCount", IllegalCount, m_ill_cnt);
    end
  end

  // Drive one cycle of inputs just after the rising edge, then wait for the falling edge.
  task automatic step(input logic [31:0] ins, input logic v, input logic s,
                      input logic f, input logic r);
    @(posedge clk);
    #1;
    InstrD = ins; ValidD = v; StallE = s; FlushE = f; reset = r;
    @(negedge clk);
  endtask

  logic [31:0] vecs [14];
  int          busy_n;

  initial begin
    vecs = '{BEQ, 32'h0020_A463, JAL, 32'h0001_00E7, JALR_BAD, LUI, 32'h4031_5093,
             32'h4031_1093, 32'h4031_00B3, 32'h4031_60B3, 32'h0002_B303,
             32'h0020_B023, 32'h0231_00B3, 32'h0000_000B};

    step(NOP, 0, 0, 0, 1);
    cmp_en = 1'b1;
    check("rst_validE", ValidE, 0);
    check("rst_busyD", BusyD, 0);
    check("rst_count", IllegalCount, 0);

    step(ADD, 1, 0, 0, 0);
    step(LW, 1, 0, 0, 0);
    check("add_regwrite", RegWriteE, 1);
    check("add_aluop", ALUOpE, 2'b10);
    check("add_resultsrc", ResultSrcE, 3'b000);
    check("add_illegal", IllegalE, 0);
    check("add_valid", ValidE, 1);
    check("lw_immsrc", ImmSrcD, 3'b000);
    step(AUIPC, 1, 0, 0, 0);
    check("lw_resultsrc", ResultSrcE, 3'b001);
    check("lw_alusrc", ALUSrcE, 1);
    check("auipc_immsrc", ImmSrcD, 3'b100);
    step(NOP, 0, 0, 0, 0);
    check("auipc_resultsrc", ResultSrcE, 3'b100);

    step(ADD, 1, 0, 0, 0);
    step(SW, 1, 1, 0, 0);
    step(SW, 1, 1, 0, 0);
    check("stall_hold_rw", RegWriteE, 1);
    check("stall_hold_mw", MemWriteE, 0);
    step(SW, 1, 1, 1, 0);
    step(SW, 1, 0, 0, 0);
    check("stall_flush_valid", ValidE, 0);
    check("stall_flush_rw", RegWriteE, 0);
    step(BEQ, 1, 0, 0, 0);
    check("sw_memwrite", MemWriteE, 1);
    check("sw_alusrc", ALUSrcE, 1);

    foreach (vecs[i]) step(vecs[i], 1, 0, 0, 0);

    step(JAL, 1, 0, 0, 0);
    step(LUI, 1, 0, 0, 0);
    check("jal_jump", JumpE, 1);
    check("jal_resultsrc", ResultSrcE, 3'b010);
    check("lui_immsrc", ImmSrcD, 3'b100);
    step(JALR_BAD, 1, 0, 0, 0);
    check("lui_resultsrc", ResultSrcE, 3'b011);
    step(NOP, 0, 0, 0, 0);
    check("jalr_bad_illegal", IllegalE, 1);
    check("jalr_bad_jalr", JalrE, 0);

    step(DIV, 1, 0, 0, 0);
`ifdef MULDIV_EN
    busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      step(ADD, 1, 0, 0, 0);
      if (i == 0) check("div_muldiv", MulDivE, 1);
      if (BusyD) busy_n++;
      else break;
    end
    check("div_busy_cycles", busy_n, DIV_CYCLES - 1);
    step(DIV, 1, 0, 0, 0);
    repeat (10) step(ADD, 1, 0, 0, 0);
    check("div_busy_before_flush", BusyD, 1);
    step(ADD, 1, 0, 1, 0);
    step(ADD, 1, 0, 0, 0);
    check("div_flush_busy", BusyD, 0);
    check("div_flush_valid", ValidE, 0);
`else
    step(ADD, 1, 0, 0, 0);
    check("div_nomd_illegal", IllegalE, 1);
    check("div_nomd_busy", BusyD, 0);
    check("div_nomd_muldiv", MulDivE, 0);
`endif

    step(DIV, 1, 0, 0, 0);
    repeat (3) step(ADD, 1, 0, 0, 0);
    step(ADD, 1, 0, 0, 1);
    step(ADD, 1, 0, 0, 0);
    check("midreset_ctrl",
          {RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, ALUOpE, JumpE, JalrE, BranchE,
           Funct3E, ValidE, IllegalE, MulDivE, BusyD}, 0);
    check("midreset_count", IllegalCount, 0);

    repeat (300) step(ALL_ONES, 1, 0, 0, 0);
    check("sat_count", IllegalCount, ILL_MAX);
    check("sat_illegal", IllegalE, 1);
    check("sat_regwrite", RegWriteE, 0);
    check("sat_memwrite", MemWriteE, 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
Parametrised RV32I(+optional M) control decoder fused with the ID/EX control pipeline register.
- Decodes the full 32-bit instruction in D: opcode, funct3 and funct7 legality.
- Registers the control word into E, with stall/flush/bubble handling.
- Flags and counts illegal instructions.
- Runs a multi-cycle busy FSM that holds E while an iterative divide executes.
- Replaces the single-cycle combinational main decoder feeding the datapath.

Parameters:
DIV_CYCLES, 32, cycles a div/rem occupies E (legal range 2..64).
ILL_CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
InstrD  in  32  instruction in Decode
ValidD  in  1  InstrD holds a real instruction
StallE  in  1  hazard unit: hold E register
FlushE  in  1  hazard unit: load bubble into E
ImmSrcD  out  3  combinational, to D-stage immediate extender: 000 I, 001 S, 010 B, 011 J, 100 U
RegWriteE  out  1  registered control
MemWriteE  out  1  registered control
ResultSrcE  out  3  000 ALU, 001 mem, 010 PC+4, 011 ImmExt (lui), 100 PC+ImmExt (auipc)
ALUSrcE  out  1  registered control
ALUOpE  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 muldiv
JumpE, JalrE, BranchE  out  1 each  registered control
Funct3E  out  3  registered funct3
ValidE  out  1  E holds a real instruction
IllegalE  out  1  E holds an illegal instruction
MulDivE  out  1  E holds an M-extension op
BusyD  out  1  request upstream stall (divide in progress)
IllegalCount  out  ILL_CNT_W  saturating count of illegal instructions entering E

Behaviour:
- Reset: all E outputs 0, BusyD 0, IllegalCount 0, FSM in IDLE. Reset mid-divide aborts the divide immediately.
- Decode is combinational on InstrD. Controls appear in E one cycle after capture (latency 1).
- Legal opcode/controls:
  - load: RegWrite, I-imm, ALUSrc, ResultSrc 001
  - store: S-imm, ALUSrc, MemWrite
  - R-type: RegWrite, ALUOp 10
  - B-type: B-imm, ALUOp 01, Branch
  - I-ALU: RegWrite, I-imm, ALUSrc, ALUOp 10
  - jal: RegWrite, J-imm, Jump, ResultSrc 010
  - jalr: RegWrite, I-imm, ALUSrc, Jalr, ResultSrc 010
  - lui: RegWrite, U-imm, ResultSrc 011
  - auipc: RegWrite, U-imm, ResultSrc 100
- Illegal conditions:
  - unknown opcode
  - load funct3 in {011,110,111}
  - store funct3 > 010
  - branch funct3 in {010,011}
  - jalr funct3 != 000
  - R-type funct7 other than 0000000, or 0100000 only with funct3 000/101
  - I-ALU shift (funct3 001/101) with bad imm[11:5]
- Illegal instructions: all control outputs 0 (including RegWrite and MemWrite), IllegalE=1, ValidE=1.
- E register update priority: reset > FlushE > busy hold > StallE > load.
  - Flush: bubble (all 0, ValidE=0).
  - Hold: keep all E outputs.
  - Load: capture decode. ValidE=ValidD. Controls zeroed when ValidD=0.
- IllegalCount increments on a load with ValidD=1 and illegal decode. It saturates at all-ones and never wraps.
- FSM states: IDLE, DIV.
  - IDLE->DIV on load of a valid div/divu/rem/remu (funct3[2]=1). Counter loads DIV_CYCLES-1.
  - In DIV: BusyD=1, the E register holds internally regardless of StallE, and the counter decrements each cycle.
  - DIV->IDLE when the counter reaches 0. BusyD falls in that same cycle.
  - FlushE in DIV: abort to IDLE and load a bubble.
  - Mul ops (funct3[2]=0) are single-cycle and do not enter DIV.
- StallE and FlushE asserted together: flush wins.

Optional Feature:
MULDIV_EN.
- Defined: funct7 0000001 with R-type is legal, giving ALUOpE=11, MulDivE=1 and the DIV FSM.
- Undefined: funct7 0000001 is illegal, MulDivE and BusyD are tied 0, and the FSM and counter are not synthesised.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants
  - ImmSrc, ResultSrc and ALUOp encodings
  - funct7 constants
  - control-word struct/bit-field order
- One sub-module, ctrl_decode_comb: pure combinational InstrD -> control word + illegal flag. The stage instantiates it and owns the register, counter and FSM.

Test Plan:
- add x1,x2,x3 (0x003100B3), ValidD=1 -> next cycle RegWriteE=1, ALUOpE=10, ResultSrcE=000, IllegalE=0, ValidE=1.
- lw x6,0(x5) (0x0002A303) then auipc x5,1 (0x00001297):
  - lw: ImmSrcD=000; next cycle ResultSrcE=001, ALUSrcE=1.
  - auipc: ImmSrcD=100; next cycle ResultSrcE=100.
- 0xFFFFFFFF for 300 cycles -> IllegalE=1, RegWriteE=MemWriteE=0, IllegalCount saturates at 255 (default width).
- StallE=1 with a new instruction -> E outputs unchanged; StallE=1 and FlushE=1 together -> bubble, ValidE=0.
- MULDIV_EN, div x1,x2,x3 (0x023140B3) -> MulDivE=1, BusyD high for exactly 31 cycles, E held. Repeat with FlushE at cycle 10 -> BusyD drops next cycle.
- Without MULDIV_EN, 0x023140B3 -> IllegalE=1, BusyD stays 0. Reset asserted mid-divide -> all outputs 0 next cycle.
